// File: rtl/ucsbece154b_bpred_gen2_if.sv
// Fetch/execute interface of the second-generation branch predictor.
//  master : fetch and execute stages (drive fetch PC and resolved-branch updates)
//  slave  : the predictor (returns the combinational prediction)
//  fetch_valid_i / pc_i                  fetch PC and advance qualifier
//  pred_taken_o / pred_target_o          predicted redirect and target
//  pred_ghr_o / pred_ras_ptr_o           checkpoint carried down the pipe with the instruction
//  upd_*                                 resolved control instruction from execute
interface ucsbece154b_bpred_gen2_if #(
    parameter int unsigned NUM_GHR_BITS = 5,
    parameter int unsigned RAS_DEPTH    = 4
);
    localparam int unsigned RAS_PTR_W = $clog2(RAS_DEPTH);

    logic                    fetch_valid_i;
    logic [31:0]             pc_i;
    logic                    pred_taken_o;
    logic [31:0]             pred_target_o;
    logic [NUM_GHR_BITS-1:0] pred_ghr_o;
    logic [RAS_PTR_W-1:0]    pred_ras_ptr_o;
    logic                    upd_valid_i;
    logic [31:0]             upd_pc_i;
    logic [31:0]             upd_target_i;
    logic [1:0]              upd_type_i;
    logic                    upd_taken_i;
    logic                    upd_mispredict_i;
    logic [NUM_GHR_BITS-1:0] upd_ghr_i;
    logic [RAS_PTR_W-1:0]    upd_ras_ptr_i;

    modport master (
        output fetch_valid_i, pc_i,
        output upd_valid_i, upd_pc_i, upd_target_i, upd_type_i, upd_taken_i,
        output upd_mispredict_i, upd_ghr_i, upd_ras_ptr_i,
        input  pred_taken_o, pred_target_o, pred_ghr_o, pred_ras_ptr_o
    );

    modport slave (
        input  fetch_valid_i, pc_i,
        input  upd_valid_i, upd_pc_i, upd_target_i, upd_type_i, upd_taken_i,
        input  upd_mispredict_i, upd_ghr_i, upd_ras_ptr_i,
        output pred_taken_o, pred_target_o, pred_ghr_o, pred_ras_ptr_o
    );
endinterface

// File: rtl/ucsbece154b_bpred_gen2.sv
// Second-generation fetch-stage branch predictor: set-associative BTB with per-entry
// type, bimodal/gshare 2-bit PHT, speculative GHR with mispredict repair, and a RAS.
// Prediction is combinational on the fetch PC; training and repair land at posedge clk.
//  clk       clock
//  reset_ni  synchronous active-low reset
//  bus       predictor side (slave) of ucsbece154b_bpred_gen2_if
module ucsbece154b_bpred_gen2 #(
    parameter int unsigned NUM_BTB_ENTRIES = 32,
    parameter int unsigned NUM_WAYS        = 2,
    parameter int unsigned NUM_GHR_BITS    = 5,
    parameter int unsigned PRED_MODE       = 1,
    parameter int unsigned RAS_DEPTH       = 4
) (
    input logic                      clk,
    input logic                      reset_ni,
    ucsbece154b_bpred_gen2_if.slave  bus
);
    localparam int unsigned NUM_SETS = NUM_BTB_ENTRIES / NUM_WAYS;
    localparam int unsigned SET_W    = $clog2(NUM_SETS);
    localparam int unsigned TAG_W    = 30 - SET_W;
    localparam int unsigned PHT_N    = 2 ** NUM_GHR_BITS;
    localparam int unsigned GHR_W    = NUM_GHR_BITS;
    localparam int unsigned PTR_W    = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W    = $clog2(RAS_DEPTH + 1);

    localparam logic [1:0] T_BR   = 2'b00;
    localparam logic [1:0] T_JAL  = 2'b01;
    localparam logic [1:0] T_CALL = 2'b10;
    localparam logic [1:0] T_RET  = 2'b11;

    // Storage
    logic             btb_valid  [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0] btb_tag    [NUM_SETS][NUM_WAYS];
    logic [31:0]      btb_target [NUM_SETS][NUM_WAYS];
    logic [1:0]       btb_type   [NUM_SETS][NUM_WAYS];
    logic             lru        [NUM_SETS];
    logic [1:0]       pht        [PHT_N];
    logic [31:0]      ras_data   [RAS_DEPTH];
    logic [GHR_W-1:0] ghr;
    logic [PTR_W-1:0] ras_ptr;
    logic [CNT_W-1:0] ras_cnt;

    // Next-state / combinational signals
    logic [GHR_W-1:0] ghr_n;
    logic [PTR_W-1:0] ras_ptr_n;
    logic [CNT_W-1:0] ras_cnt_n;
    logic             push_en_c;
    logic [PTR_W-1:0] push_idx_c;
    logic [31:0]      push_data_c;

    logic [SET_W-1:0] f_set_c;
    logic [TAG_W-1:0] f_tag_c;
    logic             f_hit_c;
    logic             f_way_c;
    logic [1:0]       f_type_c;
    logic [31:0]      f_tgt_c;
    logic [GHR_W-1:0] f_pht_idx_c;
    logic             f_dir_c;
    logic             taken_c;
    logic [31:0]      target_c;

    logic [SET_W-1:0] u_set_c;
    logic [TAG_W-1:0] u_tag_c;
    logic             u_hit_c;
    logic             u_way_c;
    logic             u_wr_c;
    logic             u_wr_way_c;
    logic [GHR_W-1:0] u_pht_idx_c;
    logic [1:0]       pht_cur_c;
    logic [1:0]       pht_n_c;
    logic             repair_c;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{bus.pc_i[1:0], bus.upd_pc_i[1:0]};

    // Fetch-side index/tag split
    assign f_set_c     = bus.pc_i[SET_W+1:2];
    assign f_tag_c     = bus.pc_i[31:SET_W+2];
    assign f_pht_idx_c = bus.pc_i[GHR_W+1:2] ^ ((PRED_MODE != 0) ? ghr : '0);

    // Fetch BTB tag match (lowest matching way wins; allocation never duplicates)
    always_comb begin
        f_hit_c = 1'b0;
        f_way_c = 1'b0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            if (!f_hit_c && btb_valid[f_set_c][w] && (btb_tag[f_set_c][w] == f_tag_c)) begin
                f_hit_c = 1'b1;
                f_way_c = 1'(w);
            end
        end
    end

    assign f_type_c = btb_type[f_set_c][f_way_c];
    assign f_tgt_c  = btb_target[f_set_c][f_way_c];
    assign f_dir_c  = pht[f_pht_idx_c][1];

    // Prediction: direction from PHT for branches, always taken for jumps; returns use RAS top
    always_comb begin
        taken_c  = 1'b0;
        target_c = 32'd0;
        if (f_hit_c) begin
            case (f_type_c)
                T_BR: begin
                    taken_c  = f_dir_c;
                    target_c = f_dir_c ? f_tgt_c : 32'd0;
                end
                T_JAL, T_CALL: begin
                    taken_c  = 1'b1;
                    target_c = f_tgt_c;
                end
                default: begin
                    taken_c  = 1'b1;
                    target_c = (ras_cnt != '0) ? ras_data[ras_ptr] : f_tgt_c;
                end
            endcase
        end
    end

    assign bus.pred_taken_o   = taken_c;
    assign bus.pred_target_o  = target_c;
    assign bus.pred_ghr_o     = ghr;
    assign bus.pred_ras_ptr_o = ras_ptr;

    // Update-side lookup
    assign u_set_c     = bus.upd_pc_i[SET_W+1:2];
    assign u_tag_c     = bus.upd_pc_i[31:SET_W+2];
    assign u_pht_idx_c = bus.upd_pc_i[GHR_W+1:2] ^ ((PRED_MODE != 0) ? bus.upd_ghr_i : '0);

    always_comb begin
        u_hit_c = 1'b0;
        u_way_c = 1'b0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            if (!u_hit_c && btb_valid[u_set_c][w] && (btb_tag[u_set_c][w] == u_tag_c)) begin
                u_hit_c = 1'b1;
                u_way_c = 1'(w);
            end
        end
    end

    // A not-taken branch that misses is never allocated
    assign u_wr_c     = bus.upd_valid_i &
                        (u_hit_c | bus.upd_taken_i | (bus.upd_type_i != T_BR));
    assign u_wr_way_c = u_hit_c ? u_way_c : ((NUM_WAYS == 2) ? lru[u_set_c] : 1'b0);

    // Saturating 2-bit counter step
    assign pht_cur_c = pht[u_pht_idx_c];
    always_comb begin
        pht_n_c = pht_cur_c;
        if (bus.upd_taken_i) begin
            if (pht_cur_c != 2'b11) pht_n_c = pht_cur_c + 2'd1;
        end else begin
            if (pht_cur_c != 2'b00) pht_n_c = pht_cur_c - 2'd1;
        end
    end

    assign repair_c = bus.upd_valid_i & bus.upd_mispredict_i;

    // Speculative GHR/RAS advance; a repair from execute takes priority over the fetch
    always_comb begin
        ghr_n       = ghr;
        ras_ptr_n   = ras_ptr;
        ras_cnt_n   = ras_cnt;
        push_en_c   = 1'b0;
        push_idx_c  = ras_ptr + PTR_W'(1);
        push_data_c = bus.pc_i + 32'd4;
        if (repair_c) begin
            ghr_n     = (bus.upd_type_i == T_BR) ?
                        {bus.upd_ghr_i[GHR_W-2:0], bus.upd_taken_i} : bus.upd_ghr_i;
            ras_ptr_n = bus.upd_ras_ptr_i;
            if (bus.upd_type_i == T_CALL) begin
                push_en_c   = 1'b1;
                push_idx_c  = bus.upd_ras_ptr_i + PTR_W'(1);
                push_data_c = bus.upd_pc_i + 32'd4;
                ras_ptr_n   = push_idx_c;
                if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt_n = ras_cnt + CNT_W'(1);
            end else if ((bus.upd_type_i == T_RET) && (ras_cnt != '0)) begin
                ras_ptr_n = bus.upd_ras_ptr_i - PTR_W'(1);
                ras_cnt_n = ras_cnt - CNT_W'(1);
            end
        end else if (bus.fetch_valid_i && f_hit_c) begin
            case (f_type_c)
                T_BR: ghr_n = {ghr[GHR_W-2:0], f_dir_c};
                T_CALL: begin
                    push_en_c = 1'b1;
                    ras_ptr_n = push_idx_c;
                    if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt_n = ras_cnt + CNT_W'(1);
                end
                T_RET: begin
                    if (ras_cnt != '0) begin
                        ras_ptr_n = ras_ptr - PTR_W'(1);
                        ras_cnt_n = ras_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state: valid bits, LRU, PHT, GHR, RAS pointer/count
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            ghr     <= '0;
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                lru[s] <= 1'b0;
                for (int w = 0; w < int'(NUM_WAYS); w++) btb_valid[s][w] <= 1'b0;
            end
            for (int i = 0; i < int'(PHT_N); i++) pht[i] <= 2'b01;
        end else begin
            ghr     <= ghr_n;
            ras_ptr <= ras_ptr_n;
            ras_cnt <= ras_cnt_n;
            if (u_wr_c) begin
                btb_valid[u_set_c][u_wr_way_c] <= 1'b1;
                lru[u_set_c] <= (NUM_WAYS == 2) ? ~u_wr_way_c : 1'b0;
            end
            if (bus.upd_valid_i && (bus.upd_type_i == T_BR)) pht[u_pht_idx_c] <= pht_n_c;
        end
    end

    // Payload storage: only meaningful behind valid bits / RAS count, so left unreset
    always_ff @(posedge clk) begin
        if (reset_ni) begin
            if (u_wr_c) begin
                btb_tag[u_set_c][u_wr_way_c]    <= u_tag_c;
                btb_target[u_set_c][u_wr_way_c] <= bus.upd_target_i;
                btb_type[u_set_c][u_wr_way_c]   <= bus.upd_type_i;
            end
            if (push_en_c) ras_data[push_idx_c] <= push_data_c;
        end
    end
endmodule

// File: tb/tb_ucsbece154b_bpred_gen2.sv
module tb_ucsbece154b_bpred_gen2;
    localparam logic [1:0] T_BR   = 2'b00;
    localparam logic [1:0] T_JAL  = 2'b01;
    localparam logic [1:0] T_CALL = 2'b10;
    localparam logic [1:0] T_RET  = 2'b11;

    logic clk;
    logic reset_ni;
    int   checks;
    int   errors;

    ucsbece154b_bpred_gen2_if #(.NUM_GHR_BITS(5), .RAS_DEPTH(4)) bif_a ();
    ucsbece154b_bpred_gen2_if #(.NUM_GHR_BITS(5), .RAS_DEPTH(4)) bif_b ();

    // gshare instance
    ucsbece154b_bpred_gen2 #(.NUM_BTB_ENTRIES(32), .NUM_WAYS(2), .NUM_GHR_BITS(5),
                             .PRED_MODE(1), .RAS_DEPTH(4))
        dut_a (.clk(clk), .reset_ni(reset_ni), .bus(bif_a.slave));

    // bimodal instance, driven with identical stimulus
    ucsbece154b_bpred_gen2 #(.NUM_BTB_ENTRIES(32), .NUM_WAYS(2), .NUM_GHR_BITS(5),
                             .PRED_MODE(0), .RAS_DEPTH(4))
        dut_b (.clk(clk), .reset_ni(reset_ni), .bus(bif_b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input logic [31:0] pc, input logic v);
        bif_a.pc_i = pc;  bif_a.fetch_valid_i = v;
        bif_b.pc_i = pc;  bif_b.fetch_valid_i = v;
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic [1:0] ty, input logic tk, input logic mp,
                           input logic [4:0] g, input logic [1:0] rp);
        bif_a.upd_valid_i = v;  bif_a.upd_pc_i = pc;  bif_a.upd_target_i = tgt;
        bif_a.upd_type_i = ty;  bif_a.upd_taken_i = tk;  bif_a.upd_mispredict_i = mp;
        bif_a.upd_ghr_i = g;    bif_a.upd_ras_ptr_i = rp;
        bif_b.upd_valid_i = v;  bif_b.upd_pc_i = pc;  bif_b.upd_target_i = tgt;
        bif_b.upd_type_i = ty;  bif_b.upd_taken_i = tk;  bif_b.upd_mispredict_i = mp;
        bif_b.upd_ghr_i = g;    bif_b.upd_ras_ptr_i = rp;
    endtask

    task automatic upd_idle();
        set_upd(1'b0, 32'd0, 32'd0, T_BR, 1'b0, 1'b0, 5'd0, 2'd0);
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] ty,
                         input logic tk, input logic [4:0] g);
        set_upd(1'b1, pc, tgt, ty, tk, 1'b0, g, 2'd0);
        tick();
        upd_idle();
    endtask

    task automatic fetch_adv(input logic [31:0] pc);
        set_fetch(pc, 1'b1);
        tick();
        set_fetch(pc, 1'b0);
    endtask

    task automatic peek(input logic [31:0] pc);
        set_fetch(pc, 1'b0);
        #1;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        set_fetch(32'h100, 1'b1);
        tick();
        tick();
        reset_ni = 1'b1;
        peek(32'h100);
        checks++; if (bif_a.pred_taken_o !== 1'b0) begin errors++; $display("FAIL reset_taken got %0b exp 0", bif_a.pred_taken_o); end
        checks++; if (bif_a.pred_target_o !== 32'h0) begin errors++; $display("FAIL reset_target got %h exp 0", bif_a.pred_target_o); end
        checks++; if (bif_a.pred_ghr_o !== 5'b0) begin errors++; $display("FAIL reset_ghr got %b exp 00000", bif_a.pred_ghr_o); end
        checks++; if (bif_a.pred_ras_ptr_o !== 2'd0) begin errors++; $display("FAIL reset_ras_ptr got %0d exp 0", bif_a.pred_ras_ptr_o); end
    endtask

    task automatic test_branch_train();
        train(32'h100, 32'h80, T_BR, 1'b1, 5'd0);
        train(32'h100, 32'h80, T_BR, 1'b1, 5'd0);
        peek(32'h100);
        checks++; if (bif_a.pred_taken_o !== 1'b1) begin errors++; $display("FAIL br2_taken got %0b exp 1", bif_a.pred_taken_o); end
        checks++; if (bif_a.pred_target_o !== 32'h80) begin errors++; $display("FAIL br2_target got %h exp 00000080", bif_a.pred_target_o); end
        train(32'h100, 32'h80, T_BR, 1'b1, 5'd0);
        train(32'h100, 32'h80, T_BR, 1'b1, 5'd0);
        peek(32'h100);
        checks++; if (bif_a.pred_taken_o !== 1'b1) begin errors++; $display("FAIL br4_taken got %0b exp 1", bif_a.pred_taken_o); end
        train(32'h100, 32'h80, T_BR, 1'b0, 5'd0);
        peek(32'h100);
        checks++; if (bif_a.pred_taken_o !== 1'b1) begin errors++; $display("FAIL br_sat_nt1 got %0b exp 1", bif_a.pred_taken_o); end
        train(32'h100, 32'h80, T_BR, 1'b0, 5'd0);
        peek(32'h100);
        checks++; if (bif_a.pred_taken_o !== 1'b0) begin errors++; $display("FAIL br_nt2_taken got %0b exp 0", bif_a.pred_taken_o); end
        checks++; if (bif_a.pred_target_o !== 32'h0) begin errors++; $display("FAIL br_nt2_target got %h exp 0", bif_a.pred_target_o); end
    endtask

    task automatic test_two_way();
        train(32'h100, 32'h80, T_BR, 1'b1, 5'd0);
        peek(32'h100);
        checks++; if (bif_a.pred_target_o !== 32'h80) begin errors++; $display("FAIL lru_pre_target got %h exp 00000080", bif_a.pred_target_o); end
        train(32'h180, 32'h300, T_JAL, 1'b1, 5'd0);
        train(32'h200, 32'h500, T_JAL, 1'b1, 5'd0);
        peek(32'h100);
        checks++; if (bif_a.pred_taken_o !== 1'b0) begin errors++; $display("FAIL lru_evict_taken got %0b exp 0", bif_a.pred_taken_o); end
        checks++; if (bif_a.pred_target_o !== 32'h0) begin errors++; $display("FAIL lru_evict_target got %h exp 0", bif_a.pred_target_o); end
        peek(32'h180);
        checks++; if (bif_a.pred_taken_o !== 1'b1) begin errors++; $display("FAIL lru_keep_taken got %0b exp 1", bif_a.pred_taken_o); end
        checks++; if (bif_a.pred_target_o !== 32'h300) begin errors++; $display("FAIL lru_keep_target got %h exp 00000300", bif_a.pred_target_o); end
        peek(32'h200);
        checks++; if (bif_a.pred_target_o !== 32'h500) begin errors++; $display("FAIL lru_new_target got %h exp 00000500", bif_a.pred_target_o); end
    endtask

    task automatic test_ras();
        logic [31:0] exp_ret [5];
        exp_ret = '{32'h58, 32'h54, 32'h50, 32'h4C, 32'h123};
        set_fetch(32'h40, 1'b0);
        set_upd(1'b1, 32'h40, 32'h400, T_CALL, 1'b1, 1'b0, 5'd0, 2'd0);
        #1;
        checks++; if (bif_a.pred_taken_o !== 1'b0) begin errors++; $display("FAIL no_bypass got %0b exp 0", bif_a.pred_taken_o); end
        tick();
        upd_idle();
        #1;
        checks++; if (bif_a.pred_taken_o !== 1'b1) begin errors++; $display("FAIL call_taken got %0b exp 1", bif_a.pred_taken_o); end
        checks++; if (bif_a.pred_target_o !== 32'h400) begin errors++; $display("FAIL call_target got %h exp 00000400", bif_a.pred_target_o); end
        train(32'h404, 32'h123, T_RET, 1'b1, 5'd0);
        fetch_adv(32'h40);
        peek(32'h404);
        checks++; if (bif_a.pred_target_o !== 32'h44) begin errors++; $display("FAIL ret_target got %h exp 00000044", bif_a.pred_target_o); end
        checks++; if (bif_a.pred_ras_ptr_o !== 2'd1) begin errors++; $display("FAIL ret_ptr got %0d exp 1", bif_a.pred_ras_ptr_o); end
        fetch_adv(32'h404);
        peek(32'h404);
        checks++; if (bif_a.pred_target_o !== 32'h123) begin errors++; $display("FAIL ret_empty_target got %h exp 00000123", bif_a.pred_target_o); end
        checks++; if (bif_a.pred_ras_ptr_o !== 2'd0) begin errors++; $display("FAIL ret_pop_ptr got %0d exp 0", bif_a.pred_ras_ptr_o); end
        train(32'h48, 32'h400, T_CALL, 1'b1, 5'd0);
        train(32'h4C, 32'h400, T_CALL, 1'b1, 5'd0);
        train(32'h50, 32'h400, T_CALL, 1'b1, 5'd0);
        train(32'h54, 32'h400, T_CALL, 1'b1, 5'd0);
        fetch_adv(32'h40);
        fetch_adv(32'h48);
        fetch_adv(32'h4C);
        fetch_adv(32'h50);
        fetch_adv(32'h54);
        peek(32'h404);
        checks++; if (bif_a.pred_ras_ptr_o !== 2'd1) begin errors++; $display("FAIL ras_wrap_ptr got %0d exp 1", bif_a.pred_ras_ptr_o); end
        for (int i = 0; i < 5; i++) begin
            peek(32'h404);
            checks++; if (bif_a.pred_target_o !== exp_ret[i]) begin errors++; $display("FAIL ras_pop%0d got %h exp %h", i, bif_a.pred_target_o, exp_ret[i]); end
            fetch_adv(32'h404);
        end
    endtask

    task automatic test_repair();
        train(32'h10C, 32'h200, T_BR, 1'b1, 5'd0);
        fetch_adv(32'h10C);
        peek(32'h10C);
        checks++; if (bif_a.pred_ghr_o !== 5'b00001) begin errors++; $display("FAIL ghr_spec got %b exp 00001", bif_a.pred_ghr_o); end
        set_fetch(32'h10C, 1'b1);
        set_upd(1'b1, 32'h10C, 32'h200, T_BR, 1'b1, 1'b1, 5'b01010, 2'd0);
        tick();
        upd_idle();
        set_fetch(32'h10C, 1'b0);
        #1;
        checks++; if (bif_a.pred_ghr_o !== 5'b10101) begin errors++; $display("FAIL ghr_repair_br got %b exp 10101", bif_a.pred_ghr_o); end
        set_upd(1'b1, 32'h200, 32'h500, T_JAL, 1'b1, 1'b1, 5'b00111, 2'd0);
        tick();
        upd_idle();
        #1;
        checks++; if (bif_a.pred_ghr_o !== 5'b00111) begin errors++; $display("FAIL ghr_repair_jal got %b exp 00111", bif_a.pred_ghr_o); end
        set_upd(1'b1, 32'h40, 32'h400, T_CALL, 1'b1, 1'b1, 5'b00111, 2'd2);
        tick();
        upd_idle();
        #1;
        checks++; if (bif_a.pred_ras_ptr_o !== 2'd3) begin errors++; $display("FAIL ras_repair_call got %0d exp 3", bif_a.pred_ras_ptr_o); end
    endtask

    task automatic test_bimodal();
        reset_ni = 1'b0;
        tick();
        reset_ni = 1'b1;
        train(32'h100, 32'h80, T_BR, 1'b1, 5'd0);
        train(32'h100, 32'h80, T_BR, 1'b1, 5'd0);
        set_upd(1'b1, 32'h304, 32'h600, T_JAL, 1'b1, 1'b1, 5'b10110, 2'd0);
        tick();
        upd_idle();
        peek(32'h100);
        checks++; if (bif_b.pred_ghr_o !== 5'b10110) begin errors++; $display("FAIL bim_ghr got %b exp 10110", bif_b.pred_ghr_o); end
        checks++; if (bif_b.pred_taken_o !== 1'b1) begin errors++; $display("FAIL bim_taken got %0b exp 1", bif_b.pred_taken_o); end
        checks++; if (bif_b.pred_target_o !== 32'h80) begin errors++; $display("FAIL bim_target got %h exp 00000080", bif_b.pred_target_o); end
        checks++; if (bif_a.pred_taken_o !== 1'b0) begin errors++; $display("FAIL gshare_ghr_index got %0b exp 0", bif_a.pred_taken_o); end
        reset_ni = 1'b0;
        set_upd(1'b1, 32'h100, 32'h80, T_BR, 1'b1, 1'b0, 5'd0, 2'd0);
        tick();
        reset_ni = 1'b1;
        upd_idle();
        peek(32'h100);
        checks++; if (bif_b.pred_taken_o !== 1'b0) begin errors++; $display("FAIL rst_mid_btb got %0b exp 0", bif_b.pred_taken_o); end
        checks++; if (bif_b.pred_ghr_o !== 5'b0) begin errors++; $display("FAIL rst_mid_ghr got %b exp 00000", bif_b.pred_ghr_o); end
        train(32'h100, 32'h80, T_BR, 1'b1, 5'd0);
        train(32'h100, 32'h80, T_BR, 1'b0, 5'd0);
        peek(32'h100);
        checks++; if (bif_b.pred_taken_o !== 1'b0) begin errors++; $display("FAIL rst_mid_pht got %0b exp 0", bif_b.pred_taken_o); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset_ni = 1'b0;
        set_fetch(32'h0, 1'b0);
        upd_idle();
        test_reset();
        test_branch_train();
        test_two_way();
        test_ras();
        test_repair();
        test_bimodal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
